// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Ports:
//   i_clk       single clock, all logic on posedge
//   i_rst_n     asynchronous assert, active-low reset; release is synchronous
//   i_sel       address decode hit for this peripheral
//   i_storeReq  CPU store strobe
//   i_loadReq   CPU load strobe
//   i_addr      byte offset, only [3:2] decoded:
//               0 TXDATA (W push byte, R 0), 1 STATUS (R), 2 DIV (R/W), 3 reserved
//   i_dataIn    store data
//   o_dataOut   registered load data, valid with o_ack and held until the next load
//   o_ack       one-cycle completion pulse per accepted access
//   o_tx        serial line, idle high, driven from a flop
module uart_tx_mmio #(
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sel,
    input  logic        i_storeReq,
    input  logic        i_loadReq,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_dataIn,
    output logic [31:0] o_dataOut,
    output logic        o_ack,
    output logic        o_tx
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          ack_q, ovf_q, ovf_d, tx_q, tx_d;
    logic [31:0]   dout_q, dout_d, status, rdata;
    logic [15:0]   div_q, div_d, lat_q, lat_d, cyc_q, cyc_d, period;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bit_q, bit_d;
    logic          accept, wr, rd, full, empty, push_req, push, pop, busy, bit_done;
    logic          unused_bits;

    assign unused_bits = ^{i_addr[1:0], i_dataIn[31:16]};

    // A request arriving while ack is still high belongs to the access just
    // completed, so a strobe held for two cycles is taken only once.
    assign accept   = i_sel && (i_storeReq || i_loadReq) && !ack_q;
    assign wr       = accept && i_storeReq;
    assign rd       = accept && i_loadReq;
    assign full     = cnt_q == 5'(FIFO_DEPTH);
    assign empty    = cnt_q == 5'd0;
    assign push_req = wr && i_addr[3:2] == 2'd0;
    assign push     = push_req && !full;
    assign pop      = state_q == IDLE && !empty;
    assign busy     = state_q != IDLE;
    assign period   = lat_q == 16'd0 ? 16'd1 : lat_q;
    assign bit_done = cyc_q == period - 16'd1;

    assign status = {24'd0, cnt_q[3:0], ovf_q, busy, empty, full};
    assign rdata  = i_addr[3:2] == 2'd1 ? status :
                    i_addr[3:2] == 2'd2 ? {16'd0, div_q} : 32'd0;

    always_comb begin
        dout_d   = rd ? rdata : dout_q;
        div_d    = (wr && i_addr[3:2] == 2'd2) ? i_dataIn[15:0] : div_q;
        // A dropped byte on the same edge as a STATUS read wins, so ovf stays set.
        ovf_d    = (push_req && full) ? 1'b1 : (rd && i_addr[3:2] == 2'd1) ? 1'b0 : ovf_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + 5'(push) - 5'(pop);
        cyc_d    = (state_q == IDLE || bit_done) ? 16'd0 : cyc_q + 16'd1;
        bit_d    = (state_q == DATA && bit_done) ? bit_q + 3'd1 : bit_q;
        sh_d     = pop ? mem_q[rd_ptr_q] : (state_q == DATA && bit_done) ? sh_q >> 1 : sh_q;
        lat_d    = pop ? div_q : lat_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q    <= 1'b0;
            dout_q   <= 32'd0;
            div_q    <= CLK_DIV;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= 5'd0;
            cyc_q    <= 16'd0;
            bit_q    <= 3'd0;
            sh_q     <= 8'd0;
            lat_q    <= 16'd0;
            tx_q     <= 1'b1;
        end else begin
            ack_q    <= accept;
            dout_q   <= dout_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            lat_q    <= lat_d;
            tx_q     <= tx_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_dataIn[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = empty ? IDLE : START;
            START:   state_d = bit_done ? DATA : START;
            DATA:    state_d = (bit_done && bit_q == 3'd7) ? STOP : DATA;
            STOP:    state_d = bit_done ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the state one cycle late through tx_q.
    always_comb begin
        tx_d = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
    end

    assign o_dataOut = dout_q;
    assign o_ack     = ack_q;
    assign o_tx      = tx_q;
endmodule
